// File: rtl/fifo_port_sched_if.sv
// FIFO-side bus between the access scheduler (master) and a synchronous FIFO (slave).
// Covers write/read strobes, output enable, almost-full programming, data and status flags.
interface fifo_port_sched_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  wr;
   logic                  rd;
   logic                  oe;
   logic                  daf;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  fifo_empty;
   logic                  fifo_full;

   modport master (
      output wr, rd, oe, daf, data_in,
      input  data_out, fifo_empty, fifo_full
   );

   modport slave (
      input  wr, rd, oe, daf, data_in,
      output data_out, fifo_empty, fifo_full
   );
endinterface

// File: rtl/fifo_port_sched.sv
// Single-clock FIFO access scheduler: round-robin write arbitration, consumer reads,
// almost-full offset programming and a shadow occupancy count guarding overflow/underflow.
module fifo_port_sched #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int FIFO_ENTRIES = 1024
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic                            rd_req_i,
   output logic                            rd_valid_o,
   output logic [DATA_WIDTH-1:0]           rd_data_o,
   input  logic                            cfg_valid_i,
   input  logic [DATA_WIDTH-1:0]           cfg_offset_i,
   output logic                            cfg_done_o,
   output logic                            cfg_err_o,
   output logic [$clog2(FIFO_ENTRIES):0]   occupancy_o,
   fifo_port_sched_if.master               fifo
);
   localparam int OCC_W = $clog2(FIFO_ENTRIES) + 1;
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {RUN, PROG_DAF, PROG_HOLD} state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  wr_q, wr_d;
   logic                  rd_q, rd_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0] rd_hold_q, rd_hold_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
   logic                  found;
   logic [PTR_W-1:0]      pick;
   logic                  grant_en;
   logic                  can_wr;
   logic                  rd_ok;
   logic                  cfg_ok;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_data[gi]    = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
         assign req_ready_o[gi] = rst_n_i && grant_en && (pick == PTR_W'(gi));
      end
   endgenerate

   // Round-robin scan starting at the pointer, wrapping past NUM_REQ-1.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid_i[PTR_W'(idx)]) begin
            found = 1'b1;
            pick  = PTR_W'(idx);
         end
      end
   end

   // An in-flight write is not yet in occ_q, an in-flight read is not yet removed from it.
   assign can_wr = !fifo.fifo_full &&
                   (({1'b0, occ_q} + (OCC_W+1)'(wr_q)) < (OCC_W+1)'(FIFO_ENTRIES));
   assign rd_ok  = rd_req_i && (occ_q > OCC_W'(rd_q)) && !fifo.fifo_empty;
   assign cfg_ok = fifo.fifo_empty && (occ_q == '0) && !wr_q && !rd_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      data_in_d = data_in_q;
      cfg_err_d = 1'b0;
      grant_en  = 1'b0;
      case (state_q)
         RUN: begin
            if (cfg_valid_i && cfg_ok) begin
               state_d   = PROG_DAF;
               data_in_d = cfg_offset_i;
            end else begin
               cfg_err_d = cfg_valid_i;
               if (can_wr && found) begin
                  grant_en  = 1'b1;
                  wr_d      = 1'b1;
                  data_in_d = req_data[pick];
                  ptr_d     = (pick == PTR_W'(NUM_REQ-1)) ? '0 : pick + PTR_W'(1);
               end
               rd_d = rd_ok;
            end
         end
         PROG_DAF:  state_d = PROG_HOLD;
         PROG_HOLD: state_d = RUN;
         default:   state_d = RUN;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      if (wr_q && !rd_q && (occ_q != OCC_W'(FIFO_ENTRIES))) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!wr_q && rd_q && (occ_q != '0)) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   // FIFO data appears the cycle after the read strobe; hold it between reads.
   always_comb begin
      rd_valid_d = rd_q;
      rd_hold_d  = rd_valid_q ? fifo.data_out : rd_hold_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= RUN;
         ptr_q      <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         data_in_q  <= '0;
         rd_hold_q  <= '0;
         occ_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
         cfg_err_q  <= cfg_err_d;
         data_in_q  <= data_in_d;
         rd_hold_q  <= rd_hold_d;
         occ_q      <= occ_d;
      end
   end

   assign fifo.wr      = wr_q;
   assign fifo.rd      = rd_q;
   assign fifo.oe      = rd_q;
   assign fifo.daf     = (state_q == PROG_DAF);
   assign fifo.data_in = data_in_q;
   assign cfg_done_o   = (state_q == PROG_HOLD);
   assign cfg_err_o    = cfg_err_q;
   assign rd_valid_o   = rd_valid_q;
   assign rd_data_o    = rd_valid_q ? fifo.data_out : rd_hold_q;
   assign occupancy_o  = occ_q;
endmodule

// File: tb/tb_fifo_port_sched.sv
// Directed bench for fifo_port_sched with a behavioural 1024-entry FIFO on the bus.
module tb_fifo_port_sched;
   localparam int NR    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 1024;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NR-1:0]       req_valid;
   logic [NR*DW-1:0]    req_data;
   logic [NR-1:0]       req_ready;
   logic                rd_req;
   logic                rd_valid;
   logic [DW-1:0]       rd_data;
   logic                cfg_valid;
   logic [DW-1:0]       cfg_offset;
   logic                cfg_done;
   logic                cfg_err;
   logic [10:0]         occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_port_sched_if #(.DATA_WIDTH(DW)) fbus ();

   fifo_port_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_ENTRIES(DEPTH)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_data_i   (req_data),
      .req_ready_o  (req_ready),
      .rd_req_i     (rd_req),
      .rd_valid_o   (rd_valid),
      .rd_data_o    (rd_data),
      .cfg_valid_i  (cfg_valid),
      .cfg_offset_i (cfg_offset),
      .cfg_done_o   (cfg_done),
      .cfg_err_o    (cfg_err),
      .occupancy_o  (occupancy),
      .fifo         (fbus.master)
   );

   // Behavioural FIFO: data registered out on the read edge.
   logic [DW-1:0] mem [DEPTH];
   logic [9:0]    wp, rp;
   logic [10:0]   cnt;
   assign fbus.fifo_empty = (cnt == 11'd0);
   assign fbus.fifo_full  = (cnt == 11'(DEPTH));

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0; rp <= '0; cnt <= '0; fbus.data_out <= '0;
      end else begin
         if (fbus.wr) begin
            mem[wp] <= fbus.data_in;
            wp      <= wp + 10'd1;
         end
         if (fbus.rd && fbus.oe) begin
            fbus.data_out <= mem[rp];
            rp            <= rp + 10'd1;
         end
         cnt <= cnt + 11'(fbus.wr) - 11'(fbus.rd && fbus.oe);
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; req_data = '1; rd_req = 1'b1;
      cfg_valid = 1'b1; cfg_offset = 16'h1234;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", req_ready); end
      checks++; if (fbus.wr !== 1'b0 || fbus.rd !== 1'b0 || fbus.oe !== 1'b0 || fbus.daf !== 1'b0) begin errors++; $display("FAIL reset_strobes: got wr%b rd%b oe%b daf%b expected 0", fbus.wr, fbus.rd, fbus.oe, fbus.daf); end
      checks++; if (fbus.data_in !== 16'h0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", fbus.data_in); end
      checks++; if (occupancy !== 11'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_misc: got rv%b rdata%h done%b err%b expected 0", rd_valid, rd_data, cfg_done, cfg_err); end
      @(negedge clk);
      req_valid = '0; req_data = '0; rd_req = 1'b0; cfg_valid = 1'b0; cfg_offset = '0; rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (fbus.wr !== 1'b0 || occupancy !== 11'd0) begin errors++; $display("FAIL post_reset: got wr%b occ%0d expected 0/0", fbus.wr, occupancy); end
      $display("test_reset done");
   endtask

   task automatic test_cfg_prog();
      @(negedge clk); cfg_valid = 1'b1; cfg_offset = 16'h0040; #1;
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_entry: got %b expected 0", cfg_err); end
      @(negedge clk); cfg_valid = 1'b0; req_valid = 4'b0001; req_data[15:0] = 16'h7777; #1;
      checks++; if (fbus.daf !== 1'b1 || fbus.data_in !== 16'h0040) begin errors++; $display("FAIL prog_daf: got daf%b data%h expected 1/0040", fbus.daf, fbus.data_in); end
      checks++; if (cfg_done !== 1'b0 || req_ready !== 4'h0 || cfg_err !== 1'b0) begin errors++; $display("FAIL prog_daf_misc: got done%b ready%h err%b expected 0", cfg_done, req_ready, cfg_err); end
      @(negedge clk); #1;
      checks++; if (fbus.daf !== 1'b0 || fbus.data_in !== 16'h0040 || cfg_done !== 1'b1) begin errors++; $display("FAIL prog_hold: got daf%b data%h done%b expected 0/0040/1", fbus.daf, fbus.data_in, cfg_done); end
      checks++; if (req_ready !== 4'h0 || fbus.wr !== 1'b0) begin errors++; $display("FAIL prog_hold_blocked: got ready%h wr%b expected 0", req_ready, fbus.wr); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (cfg_done !== 1'b0 || fbus.daf !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL prog_exit: got done%b daf%b err%b expected 0", cfg_done, fbus.daf, cfg_err); end
      $display("test_cfg_prog done");
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ready;
      req_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); req_valid = 4'hF; #1;
         exp_ready = 4'(1 << (k % 4));
         checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
         if (k > 0) begin
            checks++; if (fbus.wr !== 1'b1 || fbus.data_in !== 16'h1000 + 16'((k-1) % 4)) begin errors++; $display("FAIL rr_wr[%0d]: got wr%b data%h expected 1/%h", k, fbus.wr, fbus.data_in, 16'h1000 + 16'((k-1) % 4)); end
         end
      end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (req_ready !== 4'h0 || fbus.wr !== 1'b1 || fbus.data_in !== 16'h1003 || occupancy !== 11'd7) begin errors++; $display("FAIL rr_tail: got ready%h wr%b data%h occ%0d expected 0/1/1003/7", req_ready, fbus.wr, fbus.data_in, occupancy); end
      @(negedge clk); #1;
      checks++; if (fbus.wr !== 1'b0 || occupancy !== 11'd8) begin errors++; $display("FAIL rr_occ: got wr%b occ%0d expected 0/8", fbus.wr, occupancy); end
      $display("test_round_robin done");
   endtask

   task automatic test_fill();
      int wr_cnt = 0;
      int grants = 0;
      int rv = 0;
      logic [DW-1:0] first_data = '0;
      req_valid = 4'hF;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk); #1;
         if (fbus.wr) wr_cnt++;
         if (occupancy == 11'd1024 && req_ready == 4'h0 && !fbus.wr) break;
      end
      checks++; if (wr_cnt != 1016 || occupancy !== 11'd1024 || req_ready !== 4'h0) begin errors++; $display("FAIL fill: got wr%0d occ%0d ready%h expected 1016/1024/0", wr_cnt, occupancy, req_ready); end
      @(negedge clk); rd_req = 1'b1; #1;
      checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL full_block: got %h expected 0", req_ready); end
      @(negedge clk); rd_req = 1'b0; #1;
      checks++; if (fbus.rd !== 1'b1 || fbus.oe !== 1'b1) begin errors++; $display("FAIL full_rd: got rd%b oe%b expected 1/1", fbus.rd, fbus.oe); end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk); #1;
         if (req_ready != 4'h0) grants++;
         if (j == 0) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1000) begin errors++; $display("FAIL full_rdata: got rv%b data%h expected 1/1000", rd_valid, rd_data); end
         end
      end
      checks++; if (grants != 1 || occupancy !== 11'd1024) begin errors++; $display("FAIL refill: got grants%0d occ%0d expected 1/1024", grants, occupancy); end
      req_valid = '0; rd_req = 1'b1;
      for (int i = 0; i < 1033; i++) begin
         @(negedge clk);
         if (i == 1030) rd_req = 1'b0;
         #1;
         if (rd_valid) begin
            if (rv == 0) first_data = rd_data;
            rv++;
         end
      end
      checks++; if (rv != 1024 || occupancy !== 11'd0 || first_data !== 16'h1001) begin errors++; $display("FAIL drain: got reads%0d occ%0d first%h expected 1024/0/1001", rv, occupancy, first_data); end
      $display("test_fill done");
   endtask

   task automatic test_read_pair();
      logic [6:0]    exp_rd = 7'b0000110;
      logic [6:0]    exp_rv = 7'b0001100;
      logic [DW-1:0] exp_d;
      @(negedge clk); req_valid = 4'b0001; req_data[15:0] = 16'hA5A5; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL pair_g0: got %b expected 0001", req_ready); end
      @(negedge clk); req_valid = 4'b0010; req_data[31:16] = 16'h5A5A; #1;
      checks++; if (req_ready !== 4'b0010 || fbus.data_in !== 16'hA5A5) begin errors++; $display("FAIL pair_g1: got ready%b data%h expected 0010/A5A5", req_ready, fbus.data_in); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (fbus.data_in !== 16'h5A5A) begin errors++; $display("FAIL pair_wr1: got %h expected 5A5A", fbus.data_in); end
      @(negedge clk); #1;
      checks++; if (occupancy !== 11'd2) begin errors++; $display("FAIL pair_occ: got %0d expected 2", occupancy); end
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); rd_req = (c < 4); #1;
         checks++; if (fbus.rd !== exp_rd[c] || fbus.oe !== exp_rd[c] || rd_valid !== exp_rv[c]) begin errors++; $display("FAIL pair_seq[%0d]: got rd%b oe%b rv%b expected %b/%b/%b", c, fbus.rd, fbus.oe, rd_valid, exp_rd[c], exp_rd[c], exp_rv[c]); end
         if (exp_rv[c]) begin
            exp_d = (c == 2) ? 16'hA5A5 : 16'h5A5A;
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL pair_data[%0d]: got %h expected %h", c, rd_data, exp_d); end
         end
      end
      checks++; if (occupancy !== 11'd0) begin errors++; $display("FAIL pair_end_occ: got %0d expected 0", occupancy); end
      $display("test_read_pair done");
   endtask

   task automatic test_cfg_reject();
      req_data[15:0] = 16'h0333;
      repeat (3) begin @(negedge clk); req_valid = 4'b0001; end
      @(negedge clk); req_valid = '0;
      @(negedge clk); cfg_valid = 1'b1; cfg_offset = 16'h0077; req_valid = 4'b0001; req_data[15:0] = 16'hBEEF; #1;
      checks++; if (occupancy !== 11'd3 || req_ready !== 4'b0001) begin errors++; $display("FAIL rej_entry: got occ%0d ready%b expected 3/0001", occupancy, req_ready); end
      @(negedge clk); cfg_valid = 1'b0; req_valid = '0; #1;
      checks++; if (cfg_err !== 1'b1 || fbus.daf !== 1'b0 || fbus.wr !== 1'b1 || fbus.data_in !== 16'hBEEF) begin errors++; $display("FAIL rej_pulse: got err%b daf%b wr%b data%h expected 1/0/1/BEEF", cfg_err, fbus.daf, fbus.wr, fbus.data_in); end
      @(negedge clk); #1;
      checks++; if (cfg_err !== 1'b0 || fbus.daf !== 1'b0 || cfg_done !== 1'b0 || occupancy !== 11'd4) begin errors++; $display("FAIL rej_after: got err%b daf%b done%b occ%0d expected 0/0/0/4", cfg_err, fbus.daf, cfg_done, occupancy); end
      $display("test_cfg_reject done");
   endtask

   task automatic test_reset_abort();
      int done_seen = 0;
      rd_req = 1'b1;
      repeat (8) @(negedge clk);
      rd_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (occupancy !== 11'd0) begin errors++; $display("FAIL abort_drain: got %0d expected 0", occupancy); end
      @(negedge clk); cfg_valid = 1'b1; cfg_offset = 16'h0055;
      @(negedge clk); cfg_valid = 1'b0; #1;
      checks++; if (fbus.daf !== 1'b1) begin errors++; $display("FAIL abort_daf_pre: got %b expected 1", fbus.daf); end
      rst_n = 1'b0; #1;
      checks++; if (fbus.daf !== 1'b0 || fbus.data_in !== 16'h0 || occupancy !== 11'd0 || cfg_done !== 1'b0) begin errors++; $display("FAIL abort_prog: got daf%b data%h occ%0d done%b expected 0", fbus.daf, fbus.data_in, occupancy, cfg_done); end
      @(negedge clk); rst_n = 1'b1;
      repeat (4) begin @(negedge clk); #1; if (cfg_done) done_seen++; end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
      req_data = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
      @(negedge clk); req_valid = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (fbus.wr !== 1'b1 || occupancy !== 11'd1) begin errors++; $display("FAIL abort_stream_pre: got wr%b occ%0d expected 1/1", fbus.wr, occupancy); end
      rst_n = 1'b0; #1;
      checks++; if (fbus.wr !== 1'b0 || fbus.rd !== 1'b0 || occupancy !== 11'd0 || req_ready !== 4'h0) begin errors++; $display("FAIL abort_stream: got wr%b rd%b occ%0d ready%h expected 0", fbus.wr, fbus.rd, occupancy, req_ready); end
      @(negedge clk); rst_n = 1'b1; #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_first_grant: got %b expected 0001", req_ready); end
      @(negedge clk); #1;
      checks++; if (fbus.wr !== 1'b1 || fbus.data_in !== 16'h2000) begin errors++; $display("FAIL abort_first_wr: got wr%b data%h expected 1/2000", fbus.wr, fbus.data_in); end
      req_valid = '0;
      $display("test_reset_abort done");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cfg_prog();
      test_round_robin();
      test_fill();
      test_read_pair();
      test_cfg_reject();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
